// File: rtl/data_ram_pkg.sv
// Shared types for the MEM-stage data RAM and its lane-alignment helper.
// Access sizes follow the RISC-V funct3[1:0] encoding; 2'b11 is illegal.
package data_ram_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic size_violation(input mem_size_t size, input logic [1:0] lane);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return lane[0];
            WORD:    return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// Request/response bundle between the MEM stage (master) and the data RAM (slave).
interface data_ram_if
    import data_ram_pkg::*;
#(
    parameter int ADDR_BITS = 12
) ();

    logic                 clear_req;
    logic                 req_valid;
    logic                 write_enable;
    mem_size_t            size;
    logic                 load_unsigned;
    logic [ADDR_BITS-1:0] address;
    word_t                in;
    word_t                out;
    logic                 ready;
    logic                 misaligned;

    modport master (
        output clear_req, req_valid, write_enable, size, load_unsigned, address, in,
        input  out, ready, misaligned
    );

    modport slave (
        input  clear_req, req_valid, write_enable, size, load_unsigned, address, in,
        output out, ready, misaligned
    );

endinterface

// File: rtl/data_ram_mem_lane_align.sv
// Combinational lane steering: byte enables, store lane data, load extraction
// and extension, and alignment checking. Reused by the instruction-fetch path.
module mem_lane_align
    import data_ram_pkg::*;
(
    input  mem_size_t   size,
    input  logic        load_unsigned,
    input  logic [1:0]  lane,
    input  word_t       store_data,
    input  word_t       mem_word,
    output logic [3:0]  byte_en,
    output word_t       lane_data,
    output word_t       load_data,
    output logic        violation
);

    word_t shifted;

    always_comb begin
        shifted   = mem_word >> {lane, 3'b000};
        byte_en   = 4'b0000;
        lane_data = store_data;
        load_data = '0;
        violation = size_violation(size, lane);
        // Sub-word store data is replicated to every lane; the enables pick the live one.
        case (size)
            BYTE: begin
                byte_en   = 4'b0001 << lane;
                lane_data = {4{store_data[7:0]}};
                load_data = {{24{shifted[7] & ~load_unsigned}}, shifted[7:0]};
            end
            HALF: begin
                byte_en   = 4'b0011 << lane;
                lane_data = {2{store_data[15:0]}};
                load_data = {{16{shifted[15] & ~load_unsigned}}, shifted[15:0]};
            end
            WORD: begin
                byte_en   = 4'b1111;
                load_data = mem_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// Byte-addressable data memory with combinational reads, byte-lane writes and a
// one-word-per-cycle clear sequencer that runs after reset or on request.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_BITS      = 12,
    parameter bit USE_FORWARDING = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    data_ram_if.slave   bus
);

    localparam int                  IDX_BITS = ADDR_BITS - 2;
    localparam int                  DEPTH    = 1 << IDX_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

    word_t mem [DEPTH];

    ram_state_t          state_reg, state_next;
    logic [IDX_BITS-1:0] count_reg, count_next;

    logic [IDX_BITS-1:0] req_idx;
    word_t               rd_word, merged_word, align_word, lane_data, load_data;
    logic [3:0]          byte_en;
    logic                violation, ready, clearing, accept, store_ok;

    logic                wr_en;
    logic [IDX_BITS-1:0] wr_idx;
    logic [3:0]          wr_be;
    word_t               wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= CLEAR_ON_RESET ? CLEAR : READY;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            CLEAR: begin
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_IDX) begin
                    state_next = READY;
                    count_next = '0;
                end
            end
            READY: begin
                if (bus.clear_req) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        ready    = (state_reg == READY);
        clearing = (state_reg == CLEAR);
    end

    assign req_idx = bus.address[ADDR_BITS-1:2];
    assign rd_word = mem[req_idx];

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    // Forwarded view is only consumed on store requests; out is gated by accept below.
    assign align_word = (USE_FORWARDING && bus.write_enable) ? merged_word : rd_word;

    mem_lane_align u_align (
        .size          (bus.size),
        .load_unsigned (bus.load_unsigned),
        .lane          (bus.address[1:0]),
        .store_data    (bus.in),
        .mem_word      (align_word),
        .byte_en       (byte_en),
        .lane_data     (lane_data),
        .load_data     (load_data),
        .violation     (violation)
    );

    always_comb begin
        accept         = bus.req_valid & ready & ~violation;
        store_ok       = accept & bus.write_enable;
        bus.ready      = ready;
        bus.misaligned = bus.req_valid & ready & violation;
        bus.out        = accept ? load_data : '0;
    end

    // The array never sees the async reset; writes are held off while it is asserted.
    always_comb begin
        wr_en   = reset_n & (clearing | store_ok);
        wr_idx  = clearing ? count_reg : req_idx;
        wr_be   = clearing ? 4'b1111 : byte_en;
        wr_data = clearing ? '0 : lane_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/data_ram.md
# data_ram

Parametrised, byte-addressable data memory for the MEM stage of the pipelined core. Writes are committed synchronously, with per-byte lane enables. Reads are combinational, serve RISC-V byte, half and word accesses with sign or zero extension, and flag misaligned accesses. After reset, or on request, contents are zeroed by a one-word-per-cycle clear sequencer, because the asynchronous reset cannot clear the array directly.

## Interface
- ADDR_BITS, 12: byte-address width; DEPTH = 2^(ADDR_BITS-2) words.
- USE_FORWARDING, 0: when 1, a read in the same cycle as an accepted write sees the merged write data.
- CLEAR_ON_RESET, 1: when 1, a full clear runs after reset release; when 0, the block is ready immediately.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse: start a full clear (accepted only while ready).
- req_valid  in  1  access request this cycle.
- write_enable  in  1  1 = store, 0 = load.
- size  in  MemSize (2)  BYTE / HALF / WORD.
- load_unsigned  in  1  zero-extend sub-word loads (lbu/lhu).
- address  in  ADDR_BITS  byte address.
- in  in  Word (32)  store data; the low bits carry the sub-word value.
- out  out  Word (32)  load data, extended.
- ready  out  1  not clearing; requests are honoured.
- misaligned  out  1  current request violates alignment.

## Operation
- State machine, two states:
  - CLEAR: a counter walks the word index from 0 to DEPTH-1 and writes 0 at each index, one per cycle. ready=0. Requests are ignored and out=0. After index DEPTH-1 is written, the next state is READY.
  - READY: ready=1. A clear_req seen at a posedge moves the block to CLEAR with the counter at 0.
- clear_req is ignored while in CLEAR; it does not restart the walk.
- Alignment rules, with a = address[1:0]:
  - HALF requires a[0]=0.
  - WORD requires a=0.
  - BYTE is always aligned.
  - size encoding 2'b11 is illegal and is treated as misaligned.
- misaligned = req_valid & ready & violation. A misaligned access never writes and returns out=0.
- Stores:
  - Byte enables: BYTE → 1<<a; HALF → 2'b11<<a; WORD → 4'hF.
  - Lane data: BYTE places in[7:0] in lane a; HALF places in[15:0] in lanes a, a+1; WORD places in.
  - Unenabled bytes keep their old value.
- Loads:
  - Select the lane(s) at a from memory[address>>2].
  - Sign-extend from bit 7 or bit 15 unless load_unsigned is set; WORD loads ignore load_unsigned.
- Forwarding (USE_FORWARDING=1, accepted aligned store):
  - out is computed from the merged word, i.e. old bytes with the enabled bytes replaced, then extracted per size.
  - Because a store and a load never share a request, this applies to the store request's own out value.
- With USE_FORWARDING=0, out on a store cycle shows the pre-write contents.
- out=0 whenever req_valid=0.
- dump task: prints non-zero words as address/value, same format as the existing memory dump.

## Timing
- Reset asserted (async):
  - With CLEAR_ON_RESET=1: state=CLEAR, counter=0, ready=0, out=0, misaligned=0.
  - With CLEAR_ON_RESET=0: state=READY, ready=1.
  - Array contents are untouched while reset_n=0.
- The clear walk starts at the first posedge after reset_n rises. ready rises after exactly DEPTH posedges.
- A store commits at the posedge where req_valid & ready & write_enable & !misaligned holds.
- Load latency is 0 cycles (combinational from address and size). A load in the cycle after a store sees the new data.
- clear_req and an accepted store in the same READY cycle: the store commits and CLEAR starts next cycle, so the stored value is later zeroed.
- Reset asserted mid-clear aborts the walk. After release the walk restarts from index 0; there is no partial resume.
- The counter wraps only via the state transition. It is ADDR_BITS-2 bits wide, and index DEPTH-1 is the terminal value.

## Structure
- Shared package (types.svh):
  - MemSize enum: BYTE=0, HALF=1, WORD=2.
  - DataRamState enum: CLEAR, READY.
  - Existing Word type and WORD_ADDRESS macro.
- Sub-module mem_lane_align: purely combinational; computes the byte-enable mask, write-lane data, load extraction/extension and misalignment. It is shared with the future instruction-fetch path.
- The top level holds the array, the FSM/counter and the forwarding merge.

## Test plan
- Reset release, ADDR_BITS=6 (DEPTH 16) → ready=0 for 16 cycles, then ready=1; every word reads 0.
- WORD store 0xDEADBEEF @0x8, then BYTE store 0x11 @0x9 → WORD load @0x8 = 0xDEAD11EF; load byte @0xB signed = 0xFFFFFFDE, unsigned = 0x000000DE.
- HALF store 0x8001 @0x6 → load half @0x6 signed = 0xFFFF8001, unsigned = 0x00008001; word @0x4 upper half = 0x8001.
- Misalignment:
  - HALF store @0x3 → misaligned=1; word @0x0 unchanged.
  - WORD load @0x2 → misaligned=1, out=0.
- USE_FORWARDING=1: with 0x0 holding 0x11223344, BYTE store 0xAA @0x1 → same-cycle out = 0xFFFFFFAA (signed); with forwarding=0 → out = 0x00000033.
- Clear handling:
  - clear_req with a store in the same cycle → ready drops the next cycle; after DEPTH cycles all words read 0.
  - reset_n pulsed low mid-clear → ready stays 0 for a full DEPTH cycles after release.
